// File: rtl/rmw_pkg.sv
// Shared types and default sizes for the read-modify-write datapath.
// Imported by the interface, the register file and the top level.
package rmw_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_SET = 2'd1,
        OP_CLR = 2'd2,
        OP_TGL = 2'd3
    } op_t;

endpackage

// File: rtl/rmw_datapath_if.sv
// Request/controller/status bundle of the read-modify-write datapath.
// master drives requests and controller pulses; slave is the datapath.
interface rmw_datapath_if
    import rmw_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);

    logic          valid_in;
    logic [AW-1:0] addr;
    logic [DW-1:0] pat;
    op_t           op;
    logic          rst_mask;
    logic          shift;
    logic          wr;
    logic          busy;
    logic          done;
    logic [DW-1:0] dout;
    logic          drop;

    modport master (
        output valid_in, addr, pat, op,
        output rst_mask, shift, wr,
        input  busy, done, dout, drop
    );

    modport slave (
        input  valid_in, addr, pat, op,
        input  rst_mask, shift, wr,
        output busy, done, dout, drop
    );

endinterface

// File: rtl/rmw_regfile.sv
// Word storage: one synchronous write port, combinational read port(s),
// synchronous active-low clear. RMW_READBACK_EN adds a second read port.
module rmw_regfile
    import rmw_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
`ifdef RMW_READBACK_EN
    ,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
`endif
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Clear every word on reset, otherwise take the single write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

`ifdef RMW_READBACK_EN
    assign rb_data = mem[rb_addr];
`endif

endmodule

// File: rtl/rmw_datapath.sv
// Read-modify-write datapath: a walking one-hot mask, gated by the request
// pattern, edits a working copy of one word. Optional: RMW_READBACK_EN.
module rmw_datapath
    import rmw_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rmw_datapath_if.slave bus
`ifdef RMW_READBACK_EN
    ,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
`endif
);

    logic [DW-1:0] rd_word;
    logic [DW-1:0] work;
    logic [DW-1:0] work_nx;
    logic [DW-1:0] mask;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] pat_q;
    op_t           op_q;
    logic          busy;
    logic          done;
    logic          drop;
    logic [DW-1:0] dout;

    logic accept;
    logic do_shift;
    logic do_wr;

    assign accept   = bus.valid_in & ~busy;
    assign do_shift = bus.shift & busy & ~bus.rst_mask;
    assign do_wr    = bus.wr & busy;

    // Apply the op to every bit selected by both the mask and the pattern.
    always_comb begin
        work_nx = work;
        if (do_shift) begin
            for (int i = 0; i < DW; i++) begin
                if (mask[i] & pat_q[i]) begin
                    case (op_q)
                        OP_SET:  work_nx[i] = 1'b1;
                        OP_CLR:  work_nx[i] = 1'b0;
                        OP_TGL:  work_nx[i] = ~work[i];
                        default: work_nx[i] = work[i];
                    endcase
                end
            end
        end
    end

    // Request capture, mask walk, working word and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            work   <= '0;
            mask   <= '0;
            addr_q <= '0;
            pat_q  <= '0;
            op_q   <= OP_NOP;
            dout   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            done <= do_wr;
            drop <= bus.valid_in & busy;
            if (accept) begin
                addr_q <= bus.addr;
                pat_q  <= bus.pat;
                op_q   <= bus.op;
                work   <= rd_word;
                busy   <= 1'b1;
            end else begin
                work <= work_nx;
                if (do_wr) begin
                    dout <= work_nx;
                    busy <= 1'b0;
                end
            end
            if (bus.rst_mask) begin
                mask <= DW'(1);
            end else if (do_shift) begin
                mask <= {mask[DW-2:0], mask[DW-1]};
            end
        end
    end

    rmw_regfile #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (do_wr),
        .waddr   (addr_q),
        .wdata   (work_nx),
        .raddr   (bus.addr),
        .rdata   (rd_word)
`ifdef RMW_READBACK_EN
        ,
        .rb_addr (rd_addr),
        .rb_data (rd_data)
`endif
    );

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.dout = dout;
    assign bus.drop = drop;

endmodule
